// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and constants for the bit-serial arithmetic blocks
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SUB_W = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for serial_subtractor
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int W = SUB_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero
    );
endinterface

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - combinational half-subtractor cell, d = x - y with borrow-out
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int W = SUB_W
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int             CW   = $clog2(W + 1);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, res_q, res_d, diff_q;
    logic [CW-1:0]  cnt_q;
    logic           bin_q, borrow_q, zero_q;
    logic           d1, bo1, bit_d, bo2, bout, last_bit;

    // Full-subtractor bit cell: (a0 - b0) then minus the registered borrow-in
    half_subtractor u_hs_ab (.x(a_q[0]), .y(b_q[0]), .d(d1),    .bo(bo1));
    half_subtractor u_hs_bin(.x(d1),     .y(bin_q),  .d(bit_d), .bo(bo2));

    assign bout     = bo1 | bo2;
    assign last_bit = (cnt_q == LAST);
    assign res_d    = {bit_d, res_q[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SHIFT;
            SHIFT:   if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Published results only move on the final bit, so DONE never shows a partial value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        bin_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    bin_q <= bout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        diff_q   <= res_d;
                        borrow_q <= bout;
                        zero_q   <= (res_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;

    serial_subtractor_if #(.W(W)) bus();

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.zero} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_state got rdy=%b vld=%b diff=%h bor=%b z=%b want 1 0 00 0 0",
                     bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.zero);
        else passed++;
    endtask

    task automatic test_vectors;
        logic [W-1:0] va [5] = '{8'h35, 8'h12, 8'h00, 8'hA5, 8'hFF};
        logic [W-1:0] vb [5] = '{8'h12, 8'h35, 8'h01, 8'hA5, 8'h00};
        logic [W-1:0] vd [5] = '{8'h23, 8'hDD, 8'hFF, 8'h00, 8'hFF};
        logic         vbo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic         vz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            accept(va[i], vb[i]);
            total++;
            if (bus.in_ready !== 1'b0)
                $display("FAIL busy_after_accept[%0d] got in_ready=%b want 0", i, bus.in_ready);
            else passed++;
            wait_done(lat);
            total++;
            if (lat !== W + 1)
                $display("FAIL latency[%0d] got %0d want %0d", i, lat, W + 1);
            else passed++;
            total++;
            if ({bus.diff, bus.borrow, bus.zero} !== {vd[i], vbo[i], vz[i]})
                $display("FAIL result[%0d] got diff=%h bor=%b z=%b want %h %b %b",
                         i, bus.diff, bus.borrow, bus.zero, vd[i], vbo[i], vz[i]);
            else passed++;
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.in_ready, bus.diff} !== {1'b0, 1'b1, vd[i]})
                $display("FAIL transfer[%0d] got vld=%b rdy=%b diff=%h want 0 1 %h",
                         i, bus.out_valid, bus.in_ready, bus.diff, vd[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        bus.out_ready = 1'b0;
        accept(8'h35, 8'h12);
        wait_done(lat);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = (k == 2);
            bus.a = 8'h01;
            bus.b = 8'h00;
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.zero} !== {1'b1, 1'b0, 8'h23, 1'b0, 1'b0})
                $display("FAIL hold[%0d] got vld=%b rdy=%b diff=%h bor=%b z=%b want 1 0 23 0 0",
                         k, bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.zero);
            else passed++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready, bus.diff} !== {1'b0, 1'b1, 8'h23})
            $display("FAIL release got vld=%b rdy=%b diff=%h want 0 1 23", bus.out_valid, bus.in_ready, bus.diff);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL ignored_pulse got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int lat;
        accept(8'h55, 8'h11);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.diff, bus.in_ready} !== {1'b0, 8'h00, 1'b1})
            $display("FAIL reset_mid got vld=%b diff=%h rdy=%b want 0 00 1", bus.out_valid, bus.diff, bus.in_ready);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL after_reset got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        else passed++;
        accept(8'h80, 8'h01);
        wait_done(lat);
        total++;
        if ({bus.out_valid, bus.diff, bus.borrow, bus.zero} !== {1'b1, 8'h7F, 1'b0, 1'b0})
            $display("FAIL post_reset_op got vld=%b diff=%h bor=%b z=%b want 1 7f 0 0",
                     bus.out_valid, bus.diff, bus.borrow, bus.zero);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a, b, exp_d;
        int acc, prev_acc, guard;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 100; i++) begin
            guard = 0;
            while (!bus.in_ready && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            a = W'($urandom);
            b = W'($urandom);
            bus.a = a;
            bus.b = b;
            @(posedge clk);
            acc = cyc;
            @(negedge clk);
            bus.a = ~a;
            bus.b = a ^ b;
            if (i > 0) begin
                total++;
                if (acc - prev_acc !== W + 2)
                    $display("FAIL spacing[%0d] got %0d want %0d", i, acc - prev_acc, W + 2);
                else passed++;
            end
            prev_acc = acc;
            guard = 0;
            while (!bus.out_valid && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            exp_d = a - b;
            total++;
            if ({bus.out_valid, bus.diff, bus.borrow, bus.zero} !== {1'b1, exp_d, a < b, exp_d == '0})
                $display("FAIL b2b[%0d] a=%h b=%h got vld=%b diff=%h bor=%b z=%b want 1 %h %b %b",
                         i, a, b, bus.out_valid, bus.diff, bus.borrow, bus.zero, exp_d, a < b, exp_d == '0);
            else passed++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
